// File: rtl/lsu_ctrl.sv
// Load/store controller between the memory stage and a word-organised data memory.
// One request at a time; sub-word stores are done as read-modify-write.
module lsu_ctrl #(
  parameter bit WORD_INDEXED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_store_data,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_load_data
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // the response is a single-cycle resp_valid pulse with no back-pressure.
  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

  state_t      r_state;
  logic [1:0]  r_lane;
  logic [1:0]  r_size;
  logic        r_write;
  logic        r_unsigned;
  logic        r_err;
  logic [15:0] r_wdata;
  logic [31:0] r_word;
  logic [31:0] r_mem_address;
  logic [31:0] r_mem_store_data;

  logic        w_req_err;
  logic [31:0] w_req_mem_addr;
  logic [31:0] w_merged;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_ext;

  assign w_req_err = (req_size == 2'b11) ||
                     (req_size == 2'b01 && req_addr[0]) ||
                     (req_size == 2'b10 && req_addr[1:0] != 2'b00);

  assign w_req_mem_addr = WORD_INDEXED ? {2'b00, req_addr[31:2]} : {req_addr[31:2], 2'b00};

  // Merge uses the live memory word so the merged value is ready at the READ edge.
  always_comb begin
    w_merged = mem_load_data;
    if (r_size == 2'b00) begin
      case (r_lane)
        2'd0:    w_merged[7:0]   = r_wdata[7:0];
        2'd1:    w_merged[15:8]  = r_wdata[7:0];
        2'd2:    w_merged[23:16] = r_wdata[7:0];
        default: w_merged[31:24] = r_wdata[7:0];
      endcase
    end else if (r_lane[1]) begin
      w_merged[31:16] = r_wdata;
    end else begin
      w_merged[15:0] = r_wdata;
    end
  end

  always_comb begin
    case (r_lane)
      2'd0:    w_byte = r_word[7:0];
      2'd1:    w_byte = r_word[15:8];
      2'd2:    w_byte = r_word[23:16];
      default: w_byte = r_word[31:24];
    endcase
    w_half = r_lane[1] ? r_word[31:16] : r_word[15:0];
    case (r_size)
      2'b00:   w_load_ext = r_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load_ext = r_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load_ext = r_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= S_IDLE;
      r_lane           <= 2'b00;
      r_size           <= 2'b00;
      r_write          <= 1'b0;
      r_unsigned       <= 1'b0;
      r_err            <= 1'b0;
      r_wdata          <= 16'h0;
      r_word           <= 32'h0;
      r_mem_address    <= 32'h0;
      r_mem_store_data <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_lane     <= req_addr[1:0];
            r_size     <= req_size;
            r_write    <= req_write;
            r_unsigned <= req_unsigned;
            r_wdata    <= req_wdata[15:0];
            r_err      <= w_req_err;
            if (w_req_err) begin
              r_state <= S_RESP;
            end else begin
              r_mem_address <= w_req_mem_addr;
              if (req_write && req_size == 2'b10) begin
                r_mem_store_data <= req_wdata;
                r_state          <= S_WRITE;
              end else begin
                r_state <= S_READ;
              end
            end
          end
        end
        S_READ: begin
          r_word <= mem_load_data;
          if (r_write) begin
            r_mem_store_data <= w_merged;
            r_state          <= S_WRITE;
          end else begin
            r_state <= S_RESP;
          end
        end
        S_WRITE: r_state <= S_RESP;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready      = (r_state == S_IDLE);
  assign mem_read       = (r_state == S_READ);
  assign mem_write      = (r_state == S_WRITE);
  assign resp_valid     = (r_state == S_RESP);
  assign resp_err       = (r_state == S_RESP) && r_err;
  assign resp_rdata     = (r_state == S_RESP && !r_write && !r_err) ? w_load_ext : 32'h0;
  assign mem_address    = r_mem_address;
  assign mem_store_data = r_mem_store_data;

endmodule
